down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable down-counting timer: the decrementing counterpart to the CPU's up-counter.
- Software or control logic loads a period. The block counts down to zero on enabled cycles, then signals expiry as a one-cycle pulse plus a sticky interrupt with an acknowledge handshake.
- Optional auto-reload gives periodic ticks for the scheduler and delay loops.

Parameters:
WIDTH, 8, bit width of the count, load value and reload register

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  on this edge: capture load_value into count and reload register, arm timer
load_value  input  WIDTH  period to load
enable  input  1  count-down enable; low holds count
auto_reload  input  1  sampled at the expiry edge: 1 = reload and continue, 0 = stop
irq_ack  input  1  clears irq
value  output  WIDTH  current count
running  output  1  high while state is RUN
expired  output  1  one-cycle pulse in the cycle after the expiring edge
irq  output  1  sticky expiry flag until acknowledged
overrun  output  1  sticky: an expiry occurred while irq was still set

Behaviour:
- States: IDLE, RUN, DONE. The state, value, reload register, expired, irq and overrun are all registered.
- Reset (highest priority, synchronous):
  - state IDLE; value 0; reload 0.
  - running, expired, irq and overrun all 0.
  - A reset mid-count aborts immediately and clears a pending irq.
- Priority per edge: reset > load > count/expiry > hold.
- Load:
  - value <= load_value; reload <= load_value; overrun <= 0.
  - State becomes RUN if load_value != 0; otherwise IDLE, with no expiry ever generated for a zero load.
  - Load is accepted in any state, so a load during RUN restarts the count.
  - irq is not changed by load.
  - If load and an expiry condition coincide, load wins: no expired pulse, no irq set.
- RUN, enable=1, value > 1: value <= value - 1.
- RUN, enable=0: value, state and all flags hold.
- Expiry edge (RUN, enable=1, value == 1):
  - expired <= 1 for exactly one cycle; irq <= 1.
  - If irq was already 1 before this edge and irq_ack is not asserted, overrun <= 1.
  - If auto_reload=1: value <= reload, state stays RUN. value never reads 0, and the period is exactly reload enabled cycles.
  - If auto_reload=0: value <= 0, state <= DONE.
- DONE: value holds 0; running 0; enable is ignored; only load or reset leaves DONE.
- IDLE: value holds its last value (0 after reset); enable is ignored.
- irq_ack: irq <= 0 on the edge where it is sampled high, unless an expiry occurs on the same edge (set wins, irq stays 1).
  - Ack and expiry on the same edge with irq previously 1 does not raise overrun.
- Arithmetic: unsigned, WIDTH bits. Decrement never wraps, because value 1 is the terminal case.
- Maximum period: 2^WIDTH - 1 enabled cycles (load_value all-ones).
- expired and irq are registered outputs with no combinational input-to-output paths.

Test Plan:
- Reset:
  - Stimulus: assert reset 2 cycles with load=1, load_value=9 driven.
  - Required: value 0, running 0, expired 0, irq 0, overrun 0 (reset beats load).
- One-shot:
  - Stimulus: load 5; enable=1; auto_reload=0.
  - Required: value reads 5,4,3,2,1,0 on successive edges; expired high only in the cycle value first reads 0; irq 1 and running 0 afterwards; value stays 0 for 10 more cycles; irq_ack pulse clears irq.
- Auto-reload and overrun:
  - Stimulus: load 3; enable=1; auto_reload=1; no ack.
  - Required: value 3,2,1,3,2,1,3; expired pulses every 3 cycles; first expiry sets irq; second sets overrun=1; a new load clears overrun but not irq.
- Enable gating:
  - Stimulus: load 4; enable pattern 1,0,0,1,1,1.
  - Required: value 4,3,3,3,2,1,0; expiry is delayed by exactly the 2 disabled cycles.
- Edge cases:
  - load 0 -> running 0, no expired pulse ever.
  - load 6, then load 2 while value=3 -> value 2,1,0 with one expiry.
  - irq_ack on the same edge as an expiry -> irq stays 1.
  - load coinciding with value==1 -> no expiry, value = new load_value.
- Reset mid-run:
  - Stimulus: load 200, enable 1, reset asserted when value=150.
  - Required: next cycle value 0, running 0, irq 0; the timer remains idle until the next load.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot or auto-reload operation.
// Expiry gives a one-cycle pulse, a sticky irq with acknowledge, and a sticky overrun flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not armed; value holds its last value; enable ignored
// RUN   | counting down on enabled cycles; expiry at value == 1
// DONE  | one-shot expired; value holds 0 until load or reset
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             expired,
    output logic             irq,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_reload;
    logic             r_expired;
    logic             r_irq;
    logic             r_overrun;

    logic w_expire;

    // Expiry happens on the edge that would take the count from 1 to 0.
    assign w_expire = (r_state == RUN) && enable && (r_value == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_value   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (irq_ack) begin
                r_irq <= 1'b0;
            end
            if (load) begin
                r_value   <= load_value;
                r_reload  <= load_value;
                r_overrun <= 1'b0;
                r_state   <= (load_value != '0) ? RUN : IDLE;
            end else if (w_expire) begin
                r_expired <= 1'b1;
                r_irq     <= 1'b1;
                // An ack on the same edge consumes the old irq, so no overrun then.
                if (r_irq && !irq_ack) begin
                    r_overrun <= 1'b1;
                end
                if (auto_reload) begin
                    r_value <= r_reload;
                end else begin
                    r_value <= '0;
                    r_state <= DONE;
                end
            end else if ((r_state == RUN) && enable) begin
                r_value <= r_value - WIDTH'(1);
            end
        end
    end

    assign value   = r_value;
    assign running = (r_state == RUN);
    assign expired = r_expired;
    assign irq     = r_irq;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: the driver queues the expected post-edge outputs,
// a monitor pops and compares them one cycle at a time.
module tb_down_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       auto_reload;
    logic       irq_ack;
    logic [7:0] value;
    logic       running;
    logic       expired;
    logic       irq;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [7:0] val;
        logic       run;
        logic       exp;
        logic       irq;
        logic       ovr;
    } exp_t;

    exp_t q[$];

    down_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .irq_ack     (irq_ack),
        .value       (value),
        .running     (running),
        .expired     (expired),
        .irq         (irq),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs away from the active edge and queue what must appear after it.
    task automatic step(input string nm, input logic rst, input logic ld,
                        input logic [7:0] lv, input logic en, input logic ar,
                        input logic ack, input logic [7:0] ev, input logic er,
                        input logic ee, input logic ei, input logic eo);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        load        = ld;
        load_value  = lv;
        enable      = en;
        auto_reload = ar;
        irq_ack     = ack;
        e.nm  = nm;
        e.val = ev;
        e.run = er;
        e.exp = ee;
        e.irq = ei;
        e.ovr = eo;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({value, running, expired, irq, overrun} !==
                    {e.val, e.run, e.exp, e.irq, e.ovr}) begin
                    errors++;
                    $display("FAIL %s: got value=%0d running=%b expired=%b irq=%b overrun=%b, want value=%0d running=%b expired=%b irq=%b overrun=%b",
                             e.nm, value, running, expired, irq, overrun,
                             e.val, e.run, e.exp, e.irq, e.ovr);
                end
            end
        end
    end

    initial begin : driver
        int wait_cycles;
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0;
        auto_reload = 1'b0; irq_ack = 1'b0;

        // name        rst ld lv  en ar ak | val run exp irq ovr
        step("reset0",  1, 1, 9,   0, 0, 0,  0,   0, 0, 0, 0);
        step("reset1",  1, 1, 9,   0, 0, 0,  0,   0, 0, 0, 0);
        step("idle_en", 0, 0, 0,   1, 0, 0,  0,   0, 0, 0, 0);

        // one-shot
        step("os_load", 0, 1, 5,   1, 0, 0,  5,   1, 0, 0, 0);
        step("os_4",    0, 0, 0,   1, 0, 0,  4,   1, 0, 0, 0);
        step("os_3",    0, 0, 0,   1, 0, 0,  3,   1, 0, 0, 0);
        step("os_2",    0, 0, 0,   1, 0, 0,  2,   1, 0, 0, 0);
        step("os_1",    0, 0, 0,   1, 0, 0,  1,   1, 0, 0, 0);
        step("os_exp",  0, 0, 0,   1, 0, 0,  0,   0, 1, 1, 0);
        for (int i = 0; i < 10; i++)
            step("os_hold", 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0);
        step("os_ack",  0, 0, 0,   0, 0, 1,  0,   0, 0, 0, 0);
        step("os_idle", 0, 0, 0,   0, 0, 0,  0,   0, 0, 0, 0);

        // auto-reload and overrun
        step("ar_load", 0, 1, 3,   1, 1, 0,  3,   1, 0, 0, 0);
        step("ar_2",    0, 0, 0,   1, 1, 0,  2,   1, 0, 0, 0);
        step("ar_1",    0, 0, 0,   1, 1, 0,  1,   1, 0, 0, 0);
        step("ar_exp1", 0, 0, 0,   1, 1, 0,  3,   1, 1, 1, 0);
        step("ar_2b",   0, 0, 0,   1, 1, 0,  2,   1, 0, 1, 0);
        step("ar_1b",   0, 0, 0,   1, 1, 0,  1,   1, 0, 1, 0);
        step("ar_exp2", 0, 0, 0,   1, 1, 0,  3,   1, 1, 1, 1);
        step("ar_rld",  0, 1, 3,   1, 1, 0,  3,   1, 0, 1, 0);
        step("ar_ack",  0, 0, 0,   1, 1, 1,  2,   1, 0, 0, 0);
        step("ar_stop", 0, 1, 0,   1, 1, 0,  0,   0, 0, 0, 0);

        // enable gating
        step("eg_load", 0, 1, 4,   0, 0, 0,  4,   1, 0, 0, 0);
        step("eg_e1",   0, 0, 0,   1, 0, 0,  3,   1, 0, 0, 0);
        step("eg_e0a",  0, 0, 0,   0, 0, 0,  3,   1, 0, 0, 0);
        step("eg_e0b",  0, 0, 0,   0, 0, 0,  3,   1, 0, 0, 0);
        step("eg_e1b",  0, 0, 0,   1, 0, 0,  2,   1, 0, 0, 0);
        step("eg_e1c",  0, 0, 0,   1, 0, 0,  1,   1, 0, 0, 0);
        step("eg_exp",  0, 0, 0,   1, 0, 0,  0,   0, 1, 1, 0);
        step("eg_ack",  0, 0, 0,   0, 0, 1,  0,   0, 0, 0, 0);

        // load of zero never expires
        step("z_load",  0, 1, 0,   1, 0, 0,  0,   0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("z_hold", 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0);

        // reload mid-count
        step("rl_6",    0, 1, 6,   1, 0, 0,  6,   1, 0, 0, 0);
        step("rl_5",    0, 0, 0,   1, 0, 0,  5,   1, 0, 0, 0);
        step("rl_4",    0, 0, 0,   1, 0, 0,  4,   1, 0, 0, 0);
        step("rl_3",    0, 0, 0,   1, 0, 0,  3,   1, 0, 0, 0);
        step("rl_ld2",  0, 1, 2,   1, 0, 0,  2,   1, 0, 0, 0);
        step("rl_1",    0, 0, 0,   1, 0, 0,  1,   1, 0, 0, 0);
        step("rl_exp",  0, 0, 0,   1, 0, 0,  0,   0, 1, 1, 0);
        step("rl_done", 0, 0, 0,   1, 0, 0,  0,   0, 0, 1, 0);
        step("rl_ack",  0, 0, 0,   0, 0, 1,  0,   0, 0, 0, 0);

        // ack coinciding with expiry: set wins, no overrun
        step("ak_load", 0, 1, 1,   1, 1, 0,  1,   1, 0, 0, 0);
        step("ak_exp1", 0, 0, 0,   1, 1, 0,  1,   1, 1, 1, 0);
        step("ak_exp2", 0, 0, 0,   1, 1, 1,  1,   1, 1, 1, 0);
        step("ak_exp3", 0, 0, 0,   1, 0, 1,  0,   0, 1, 1, 0);
        step("ak_clr",  0, 0, 0,   0, 0, 1,  0,   0, 0, 0, 0);

        // load coinciding with value == 1
        step("lc_load", 0, 1, 2,   1, 0, 0,  2,   1, 0, 0, 0);
        step("lc_1",    0, 0, 0,   1, 0, 0,  1,   1, 0, 0, 0);
        step("lc_ld7",  0, 1, 7,   1, 0, 0,  7,   1, 0, 0, 0);
        step("lc_6",    0, 0, 0,   1, 0, 0,  6,   1, 0, 0, 0);

        // reset mid-run with an irq pending
        step("rr_ld1",  0, 1, 1,   1, 0, 0,  1,   1, 0, 0, 0);
        step("rr_exp",  0, 0, 0,   1, 0, 0,  0,   0, 1, 1, 0);
        step("rr_ld",   0, 1, 200, 1, 0, 0,  200, 1, 0, 1, 0);
        for (int i = 199; i >= 150; i--)
            step("rr_cnt", 0, 0, 0, 1, 0, 0, 8'(i), 1, 0, 1, 0);
        step("rr_rst",  1, 0, 0,   1, 0, 0,  0,   0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("rr_idle", 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0);

        // maximum period starts from all-ones
        step("mx_load", 0, 1, 255, 1, 0, 0,  255, 1, 0, 0, 0);
        step("mx_254",  0, 0, 0,   1, 0, 0,  254, 1, 0, 0, 0);

        @(negedge clk);
        enable = 1'b0; load = 1'b0; irq_ack = 1'b0;
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
